// File: rtl/ray_pkg.sv
// Shared types and constants for the raycaster column scheduler.
package ray_pkg;
  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 240;
  localparam int FIFO_DEPTH    = 4;

  typedef struct packed {
    logic [8:0]  hcount;
    logic [15:0] lineHeight;
    logic        wallType;
    logic [7:0]  mapData;
    logic [15:0] wallX;
  } col_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
endpackage

// File: rtl/column_fifo.sv
// First-word-fall-through FIFO of column results; pointers carry an extra wrap bit.
module column_fifo
  import ray_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  col_t wdata,
  input  logic pop,
  output col_t rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  col_t        mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/ray_column_scheduler.sv
// Frame controller: issues one ray per column, buffers DDA results, hands
// them to the flattener in order, with credits bounding outstanding rays.
module ray_column_scheduler
  import ray_pkg::*;
#(
  parameter int SCREEN_WIDTH  = ray_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = ray_pkg::SCREEN_HEIGHT,
  parameter int FIFO_DEPTH    = ray_pkg::FIFO_DEPTH
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  output logic        ray_req_valid_out,
  input  logic        ray_req_ready_in,
  output logic [8:0]  ray_req_hcount_out,
  input  logic        ray_res_valid_in,
  output logic        ray_res_ready_out,
  input  logic [8:0]  ray_res_hcount_in,
  input  logic [15:0] lineHeight_in,
  input  logic        wallType_in,
  input  logic [7:0]  mapData_in,
  input  logic [15:0] wallX_in,
  output logic        col_valid_out,
  input  logic        col_ready_in,
  output logic [8:0]  col_hcount_out,
  output logic [15:0] col_lineHeight_out,
  output logic        col_wallType_out,
  output logic [7:0]  col_mapData_out,
  output logic [15:0] col_wallX_out,
  output logic        frame_busy_out,
  output logic        frame_done_out,
  output logic        order_err_out,
  output logic        overrun_out
);
  localparam int          CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [8:0]  LAST_COL = 9'(SCREEN_WIDTH - 1);
  localparam logic [15:0] MAX_LH   = 16'(SCREEN_HEIGHT);

  state_e        state_q, state_d;
  logic [8:0]    issue_cnt_q, issue_cnt_d, exp_cnt_q, exp_cnt_d, out_cnt_q, out_cnt_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          order_err_q, order_err_d, overrun_q, overrun_d;
  logic          req_fire, res_fire, push, col_fire, fifo_full, fifo_empty;
  col_t          wr_col, rd_col;

  // Valid depends only on registered state, never on ray_req_ready_in.
  assign ray_req_valid_out  = (state_q == ISSUE) && (credits_q != '0);
  assign ray_req_hcount_out = issue_cnt_q;
  assign ray_res_ready_out  = !fifo_full;
  assign req_fire           = ray_req_valid_out && ray_req_ready_in;
  assign res_fire           = ray_res_valid_in && ray_res_ready_out;
  assign push               = res_fire && (state_q != IDLE);
  assign col_valid_out      = !fifo_empty;
  assign col_fire           = col_valid_out && col_ready_in;
  assign frame_busy_out     = (state_q != IDLE);
  assign frame_done_out     = (state_q == DRAIN) && col_fire && (out_cnt_q == LAST_COL);
  assign order_err_out      = order_err_q;
  assign overrun_out        = overrun_q;

  // Entries are tagged with the expected index, not the reported one.
  always_comb begin
    wr_col            = '0;
    wr_col.hcount     = exp_cnt_q;
    wr_col.lineHeight = (lineHeight_in > MAX_LH) ? MAX_LH : lineHeight_in;
    wr_col.wallType   = wallType_in;
    wr_col.mapData    = mapData_in;
    wr_col.wallX      = wallX_in;
  end

  column_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (pixel_clk_in),
    .rst_n (rst_in),
    .push  (push),
    .wdata (wr_col),
    .pop   (col_fire),
    .rdata (rd_col),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign col_hcount_out     = rd_col.hcount;
  assign col_lineHeight_out = rd_col.lineHeight;
  assign col_wallType_out   = rd_col.wallType;
  assign col_mapData_out    = rd_col.mapData;
  assign col_wallX_out      = rd_col.wallX;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    exp_cnt_d   = exp_cnt_q;
    out_cnt_d   = out_cnt_q;
    order_err_d = order_err_q;
    overrun_d   = frame_start_in && (state_q != IDLE);
    credits_d   = credits_q - CW'(req_fire) + CW'(col_fire);
    // Results with no frame active are dropped but still flagged.
    if (res_fire && ((state_q == IDLE) || (ray_res_hcount_in != exp_cnt_q))) order_err_d = 1'b1;
    if (push)     exp_cnt_d = exp_cnt_q + 9'd1;
    if (col_fire) out_cnt_d = out_cnt_q + 9'd1;
    case (state_q)
      IDLE: if (frame_start_in) begin
        state_d     = ISSUE;
        issue_cnt_d = '0;
        exp_cnt_d   = '0;
        out_cnt_d   = '0;
        order_err_d = 1'b0;
      end
      ISSUE: if (req_fire) begin
        issue_cnt_d = issue_cnt_q + 9'd1;
        if (issue_cnt_q == LAST_COL) state_d = DRAIN;
      end
      DRAIN: if (frame_done_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      exp_cnt_q   <= '0;
      out_cnt_q   <= '0;
      credits_q   <= CW'(FIFO_DEPTH);
      order_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      exp_cnt_q   <= exp_cnt_d;
      out_cnt_q   <= out_cnt_d;
      credits_q   <= credits_d;
      order_err_q <= order_err_d;
      overrun_q   <= overrun_d;
    end
  end
endmodule

// File: tb/tb_ray_column_scheduler.sv
// Directed bench: a DDA responder returns results 3 cycles after each request;
// per-scenario tasks check frame, credit, clamp, order, overrun and reset behaviour.
module tb_ray_column_scheduler;
  import ray_pkg::*;

  logic clk = 0, rst_n = 0, frame_start = 0;
  logic req_valid, req_ready = 1, res_valid = 0, res_ready;
  logic [8:0] req_hc, res_hc = '0, col_hc;
  logic [15:0] lh_in = '0, wx_in = '0, col_lh, col_wx;
  logic wt_in = 0, col_wt, col_valid, col_ready = 1;
  logic [7:0] md_in = '0, col_md;
  logic busy, done, oerr, ovr;
  int n_chk = 0, n_fail = 0;

  typedef struct {int hc; int due;} pend_t;
  pend_t pend[$];
  int    req_log[$];
  col_t  col_log[$];
  int    cyc = 0, done_cnt = 0, ovr_cnt = 0, acc_cnt = 0, bad_col = -1;
  bit    res_acc = 0;

  always #5 clk = ~clk;

  ray_column_scheduler dut (
    .pixel_clk_in(clk), .rst_in(rst_n), .frame_start_in(frame_start),
    .ray_req_valid_out(req_valid), .ray_req_ready_in(req_ready), .ray_req_hcount_out(req_hc),
    .ray_res_valid_in(res_valid), .ray_res_ready_out(res_ready), .ray_res_hcount_in(res_hc),
    .lineHeight_in(lh_in), .wallType_in(wt_in), .mapData_in(md_in), .wallX_in(wx_in),
    .col_valid_out(col_valid), .col_ready_in(col_ready), .col_hcount_out(col_hc),
    .col_lineHeight_out(col_lh), .col_wallType_out(col_wt), .col_mapData_out(col_md),
    .col_wallX_out(col_wx), .frame_busy_out(busy), .frame_done_out(done),
    .order_err_out(oerr), .overrun_out(ovr)
  );

  function automatic logic [15:0] lh_of(input int hc);
    case (hc)
      0: return 16'd500;
      1: return 16'd240;
      2: return 16'd17;
      default: return 16'((hc * 7) % 600);
    endcase
  endfunction

  // DDA model and handshake monitor: drive at negedge, sample 1ns later.
  initial begin
    pend_t p;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend.delete();
        res_valid = 0;
        res_acc   = 0;
      end else if (res_acc || !res_valid) begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          p = pend.pop_front();
          res_valid = 1;
          res_hc    = 9'((p.hc == bad_col) ? p.hc + 1 : p.hc);
          lh_in     = lh_of(p.hc);
          wt_in     = p.hc[0];
          md_in     = 8'(p.hc ^ 'h5A);
          wx_in     = 16'(p.hc * 3 + 1000);
        end else res_valid = 0;
      end
      #1;
      res_acc = res_valid && res_ready;
      if (res_acc) acc_cnt++;
      if (req_valid && req_ready) begin
        req_log.push_back(int'(req_hc));
        pend.push_back('{int'(req_hc), cyc + 3});
      end
      if (col_valid && col_ready) col_log.push_back('{col_hc, col_lh, col_wt, col_md, col_wx});
      if (done) done_cnt++;
      if (ovr) ovr_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic clear_logs();
    req_log.delete(); col_log.delete();
    done_cnt = 0; ovr_cnt = 0; acc_cnt = 0;
  endtask

  task automatic start_frame();
    @(negedge clk); frame_start = 1;
    @(negedge clk); frame_start = 0;
    #2;
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == 0 && k < 4000) begin tick(); k++; end
    if (done_cnt == 0) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: no frame_done_out within 4000 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(3);
    n_chk++;
    if ({req_valid, col_valid, busy, done, oerr, ovr, res_ready} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000001", {req_valid, col_valid, busy, done, oerr, ovr, res_ready});
    end
    n_chk++;
    if (req_hc !== 9'd0) begin n_fail++; $display("FAIL reset_hcount: got %0d want 0", req_hc); end
    @(negedge clk); rst_n = 1;
    tick(2);
  endtask

  task automatic test_frame();
    col_t e;
    clear_logs();
    start_frame();
    n_chk++;
    if (req_valid !== 1'b1 || req_hc !== 9'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_req: valid=%b hc=%0d busy=%b want 1 0 1", req_valid, req_hc, busy);
    end
    wait_done();
    tick();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy); end
    tick(10);
    n_chk++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL done_once: got %0d want 1", done_cnt); end
    n_chk++;
    if (req_log.size() != 320 || col_log.size() != 320) begin
      n_fail++;
      $display("FAIL frame_sizes: req=%0d col=%0d want 320 320", req_log.size(), col_log.size());
    end
    for (int i = 0; i < 320 && i < req_log.size(); i++) begin
      n_chk++;
      if (req_log[i] != i) begin n_fail++; $display("FAIL req_order[%0d]: got %0d want %0d", i, req_log[i], i); end
    end
    for (int i = 0; i < 320 && i < col_log.size(); i++) begin
      e.hcount     = 9'(i);
      e.lineHeight = (lh_of(i) > 16'd240) ? 16'd240 : lh_of(i);
      e.wallType   = 1'(i % 2);
      e.mapData    = 8'(i ^ 'h5A);
      e.wallX      = 16'(i * 3 + 1000);
      n_chk++;
      if (col_log[i] !== e) begin n_fail++; $display("FAIL col_data[%0d]: got %h want %h", i, col_log[i], e); end
    end
  endtask

  task automatic test_clamp();
    logic [15:0] want [3];
    want[0] = 16'd240; want[1] = 16'd240; want[2] = 16'd17;
    for (int i = 0; i < 3 && i < col_log.size(); i++) begin
      n_chk++;
      if (col_log[i].lineHeight !== want[i]) begin
        n_fail++;
        $display("FAIL clamp[%0d]: got %0d want %0d", i, col_log[i].lineHeight, want[i]);
      end
    end
  endtask

  task automatic test_credits();
    int k = 0;
    clear_logs();
    @(negedge clk); col_ready = 0;
    start_frame();
    tick(30);
    n_chk++;
    if (req_log.size() != 4) begin
      n_fail++; $display("FAIL credit_stall: got %0d requests want 4", req_log.size());
    end else begin
      n_chk++;
      if (req_log[0] != 0 || req_log[1] != 1 || req_log[2] != 2 || req_log[3] != 3) begin
        n_fail++; $display("FAIL credit_order: got %0d %0d %0d %0d want 0 1 2 3", req_log[0], req_log[1], req_log[2], req_log[3]);
      end
    end
    n_chk++;
    if (req_valid !== 1'b0 || col_valid !== 1'b1) begin
      n_fail++; $display("FAIL credit_valids: req_valid=%b col_valid=%b want 0 1", req_valid, col_valid);
    end
    @(negedge clk); col_ready = 1;
    #2;
    while (req_log.size() < 5 && k < 50) begin tick(); k++; end
    n_chk++;
    if (req_log.size() < 5 || req_log[4] != 4) begin
      n_fail++; $display("FAIL credit_resume: got %0d requests want resume at hcount 4", req_log.size());
    end
    wait_done();
    n_chk++;
    if (col_log.size() != 320) begin n_fail++; $display("FAIL credit_cols: got %0d want 320", col_log.size()); end
  endtask

  task automatic test_order();
    clear_logs();
    bad_col = 5;
    start_frame();
    wait_done();
    bad_col = -1;
    n_chk++;
    if (oerr !== 1'b1) begin n_fail++; $display("FAIL order_err_set: got %b want 1", oerr); end
    n_chk++;
    if (col_log.size() < 7 || col_log[5].hcount !== 9'd5 || col_log[6].hcount !== 9'd6) begin
      n_fail++; $display("FAIL order_tag: col 5/6 hcount not 5/6 (logged %0d cols)", col_log.size());
    end
    tick(3);
    n_chk++;
    if (oerr !== 1'b1) begin n_fail++; $display("FAIL order_err_sticky: got %b want 1", oerr); end
    clear_logs();
    start_frame();
    n_chk++;
    if (oerr !== 1'b0) begin n_fail++; $display("FAIL order_err_clear: got %b want 0", oerr); end
    wait_done();
    tick(2);
  endtask

  task automatic test_overrun();
    int k = 0;
    clear_logs();
    start_frame();
    while (req_log.size() < 100 && k < 2000) begin tick(); k++; end
    @(negedge clk); frame_start = 1;
    @(negedge clk); frame_start = 0;
    #2;
    wait_done();
    tick(5);
    n_chk++;
    if (ovr_cnt != 1) begin n_fail++; $display("FAIL overrun_pulse: got %0d cycles want 1", ovr_cnt); end
    n_chk++;
    if (done_cnt != 1 || col_log.size() != 320 || req_log.size() != 320) begin
      n_fail++; $display("FAIL overrun_frame: done=%0d cols=%0d reqs=%0d want 1 320 320", done_cnt, col_log.size(), req_log.size());
    end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL overrun_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_midframe();
    int k = 0;
    clear_logs();
    start_frame();
    while (col_log.size() < 150 && k < 2000) begin tick(); k++; end
    @(negedge clk); col_ready = 0;
    #2;
    k = 0;
    while (acc_cnt - col_log.size() < 3 && k < 50) begin tick(); k++; end
    @(negedge clk); rst_n = 0;
    #2;
    n_chk++;
    if ({req_valid, col_valid, busy, done, oerr, ovr, res_ready} !== 7'b0000001 || req_hc !== 9'd0) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b hc=%0d want 0000001 hc=0", {req_valid, col_valid, busy, done, oerr, ovr, res_ready}, req_hc);
    end
    tick();
    @(negedge clk); rst_n = 1; col_ready = 1;
    tick(3);
    n_chk++;
    if (col_valid !== 1'b0 || busy !== 1'b0 || oerr !== 1'b0) begin
      n_fail++; $display("FAIL midreset_after: col_valid=%b busy=%b oerr=%b want 0 0 0", col_valid, busy, oerr);
    end
    clear_logs();
    start_frame();
    n_chk++;
    if (req_valid !== 1'b1 || req_hc !== 9'd0) begin
      n_fail++; $display("FAIL restart_req: valid=%b hc=%0d want 1 0", req_valid, req_hc);
    end
    wait_done();
    tick(3);
    n_chk++;
    if (done_cnt != 1 || col_log.size() != 320 || oerr !== 1'b0) begin
      n_fail++; $display("FAIL restart_frame: done=%0d cols=%0d oerr=%b want 1 320 0", done_cnt, col_log.size(), oerr);
    end
    for (int i = 0; i < 320 && i < col_log.size(); i++) begin
      n_chk++;
      if (col_log[i].hcount !== 9'(i)) begin
        n_fail++; $display("FAIL restart_col[%0d]: got %0d want %0d", i, col_log[i].hcount, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_clamp();
    test_credits();
    test_order();
    test_overrun();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
